// File: rtl/byte_decode_stream.sv
// Streaming ByteDecode_d: unpacks one 32*D-byte polynomial into NCOEF D-bit coefficients, LSB-first.
// Build option BYTE_DECODE_DECOMPRESS_EN adds a decompress stage ahead of the output register (12-bit out_coeff).

`ifdef BYTE_DECODE_DECOMPRESS_EN
module decompress #(
  parameter int D = 1
) (
  input  logic [D-1:0] y_i,
  output logic [11:0]  x_o
);
  logic [23:0] prod;

  // Round-to-nearest of q*y/2^D, with q = 3329.
  assign prod = 24'd3329 * 24'(y_i) + 24'(1 << (D - 1));
  assign x_o  = 12'(prod >> D);
endmodule
`endif

module byte_decode_stream #(
  parameter int D     = 1,
  parameter int NCOEF = 256,
`ifdef BYTE_DECODE_DECOMPRESS_EN
  localparam int OUT_W = 12
`else
  localparam int OUT_W = D
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_coeff,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);
  localparam int BUF_W  = D + 7;
  localparam int FILL_W = $clog2(D + 8);
  localparam int NBYTES = NCOEF * D / 8;
  localparam int BCNT_W = $clog2(NBYTES + 1);
  localparam int CCNT_W = $clog2(NCOEF);

  if (!(D == 1 || D == 4 || D == 5 || D == 10 || D == 11)) begin : g_bad_d
    $error("byte_decode_stream: D must be one of 1, 4, 5, 10, 11");
  end
  if (NCOEF % 8 != 0) begin : g_bad_ncoef
    $error("byte_decode_stream: NCOEF must be a multiple of 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [CCNT_W-1:0]  ccnt_q, ccnt_d;
  logic [OUT_W-1:0]   coeff_q, coeff_d;
  logic               in_fire, out_fire;

  // Accept needs fill<D and emit needs fill>=D, so at most one of them fires per cycle.
  assign in_ready  = (state_q == RUN) && (fill_q < FILL_W'(D)) && (bcnt_q < BCNT_W'(NBYTES));
  assign out_valid = (state_q == RUN) && (fill_q >= FILL_W'(D));
  assign out_last  = out_valid && (ccnt_q == CCNT_W'(NCOEF - 1));
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_coeff = coeff_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d = state_q;
    buf_d   = buf_q;
    fill_d  = fill_q;
    bcnt_d  = bcnt_q;
    ccnt_d  = ccnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          buf_d   = '0;
          fill_d  = '0;
          bcnt_d  = '0;
          ccnt_d  = '0;
        end
      end
      RUN: begin
        if (in_fire) begin
          buf_d  = buf_q | (BUF_W'(in_byte) << fill_q);
          fill_d = fill_q + FILL_W'(8);
          bcnt_d = bcnt_q + BCNT_W'(1);
        end else if (out_fire) begin
          buf_d  = buf_q >> D;
          fill_d = fill_q - FILL_W'(D);
          ccnt_d = ccnt_q + CCNT_W'(1);
          if (ccnt_q == CCNT_W'(NCOEF - 1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The output register tracks the next buffer head, so out_coeff holds while out_valid stalls.
`ifdef BYTE_DECODE_DECOMPRESS_EN
  logic [11:0] dec_x;
  decompress #(.D(D)) u_decompress (
    .y_i(buf_d[D-1:0]),
    .x_o(dec_x)
  );
  assign coeff_d = dec_x;
`else
  assign coeff_d = buf_d[D-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use non-blocking assignments only; the datapath is reset as well so all outputs read 0.
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      fill_q  <= '0;
      bcnt_q  <= '0;
      ccnt_q  <= '0;
      coeff_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      bcnt_q  <= bcnt_d;
      ccnt_q  <= ccnt_d;
      coeff_q <= coeff_d;
    end
  end
endmodule

// File: tb/tb_byte_decode_stream.sv
// Self-checking bench: five byte_decode_stream instances (D=1,4,5,10,11) against a bit-stream reference model.
module tb_byte_decode_stream;
  localparam int NI    = 5;
  localparam int NCOEF = 256;
`ifdef BYTE_DECODE_DECOMPRESS_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  function automatic int d_of(input int g);
    case (g)
      0:       return 1;
      1:       return 4;
      2:       return 5;
      3:       return 10;
      default: return 11;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NI-1:0] start = '0, in_valid = '0, out_ready = '0;
  logic [7:0]    in_byte [NI];
  logic [NI-1:0] in_ready, out_valid, out_last, busy, done;
  logic [NI-1:0][11:0] out_coeff;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DG = d_of(g);
    localparam int OW = DEC ? 12 : DG;
    logic [OW-1:0] oc;
    byte_decode_stream #(.D(DG), .NCOEF(NCOEF)) u_dut (
      .clk(clk), .rst(rst), .start(start[g]),
      .in_byte(in_byte[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .out_coeff(oc), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_last(out_last[g]), .busy(busy[g]), .done(done[g])
    );
    assign out_coeff[g] = 12'(oc);
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the accepted bytes form one bit stream; coefficient j is bits [j*D +: D].
  bit         m_run [NI];
  bit         m_done[NI];
  int         nacc  [NI];
  int         nout  [NI];
  logic [7:0] acc_mem [NI][352];
  logic [11:0] cap    [NI][NCOEF];
  logic [7:0] stim [352];

  function automatic int ref_coeff(input int i, input int j);
    int d, v, idx;
    d = d_of(i);
    v = 0;
    for (int b = 0; b < d; b++) begin
      idx = j * d + b;
      v |= int'(acc_mem[i][idx / 8][idx % 8]) << b;
    end
    if (DEC) v = (3329 * v + (1 << (d - 1))) >> d;
    return v;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int d, avail;
      bit e_ov, e_ir;
      d = d_of(i);
      if (rst) begin
        check($sformatf("rst_outputs[%0d]", i),
              {in_ready[i], out_valid[i], out_last[i], busy[i], done[i], out_coeff[i]}, 0);
        m_run[i] = 0; m_done[i] = 0; nacc[i] = 0; nout[i] = 0;
      end else begin
        avail = 8 * nacc[i] - d * nout[i];
        e_ov  = m_run[i] && avail >= d;
        e_ir  = m_run[i] && avail < d && nacc[i] < NCOEF * d / 8;
        check($sformatf("busy[%0d]", i), busy[i], int'(m_run[i] || m_done[i]));
        check($sformatf("done[%0d]", i), done[i], int'(m_done[i]));
        check($sformatf("in_ready[%0d]", i), in_ready[i], int'(e_ir));
        check($sformatf("out_valid[%0d]", i), out_valid[i], int'(e_ov));
        check($sformatf("out_last[%0d]", i), out_last[i], int'(e_ov && nout[i] == NCOEF - 1));
        if (e_ov)
          check($sformatf("coeff[%0d][%0d]", i, nout[i]), out_coeff[i], ref_coeff(i, nout[i]));
        if (m_done[i]) begin
          m_done[i] = 0;
        end else if (m_run[i]) begin
          if (in_valid[i] && e_ir) begin
            acc_mem[i][nacc[i]] = in_byte[i];
            nacc[i]++;
          end else if (e_ov && out_ready[i]) begin
            cap[i][nout[i]] = out_coeff[i];
            if (nout[i] == NCOEF - 1) begin
              m_run[i]  = 0;
              m_done[i] = 1;
            end
            nout[i]++;
          end
        end else if (start[i]) begin
          m_run[i] = 1; nacc[i] = 0; nout[i] = 0;
        end
      end
    end
  end

  // Called at posedge+1; pulses start, then streams stim with random valid/ready and stray starts.
  task automatic run_stream(input int i, input int stop_at, input int pv, input int pr, output int cycles);
    int bi, hs, nb;
    bit fi, fo;
    nb = NCOEF * d_of(i) / 8;
    bi = 0; hs = 0; cycles = 0;
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    while (hs < NCOEF && bi < stop_at && cycles < 20000) begin
      in_valid[i]  = (bi < nb) && ($urandom_range(99) < pv);
      in_byte[i]   = in_valid[i] ? stim[bi] : 8'($urandom);
      out_ready[i] = ($urandom_range(99) < pr);
      start[i]     = ($urandom_range(15) == 0);
      @(negedge clk);
      fi = in_valid[i] && in_ready[i];
      fo = out_valid[i] && out_ready[i];
      @(posedge clk); #1;
      bi += int'(fi);
      hs += int'(fo);
      cycles++;
    end
    in_valid[i] = 1'b0; out_ready[i] = 1'b0; start[i] = 1'b0;
    if (stop_at >= nb) check($sformatf("handshakes[%0d]", i), hs, NCOEF);
  endtask

  task automatic idle_probe(input int i);
    in_valid[i] = 1'b1;
    in_byte[i]  = 8'($urandom);
    repeat (4) @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nz, y0;
    logic [7:0] pat;
    for (int i = 0; i < NI; i++) in_byte[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // D=1: 0xA5 then zeros, full rate.
    for (int k = 0; k < 352; k++) stim[k] = 8'h00;
    stim[0] = 8'hA5;
    run_stream(0, 1000, 100, 100, cyc);
    check("d1_cycles", cyc, 288);
    pat = 8'hA5;
    for (int k = 0; k < 8; k++) check($sformatf("d1_pin[%0d]", k), cap[0][k], pat[k] ? (DEC ? 1665 : 1) : 0);
    nz = 0;
    for (int k = 8; k < NCOEF; k++) if (cap[0][k] != 12'd0) nz++;
    check("d1_tail_nonzero", nz, 0);
    idle_probe(0);

    // D=4: 0x3C,0x21 then random, full rate.
    for (int k = 0; k < 352; k++) stim[k] = 8'($urandom);
    stim[0] = 8'h3C; stim[1] = 8'h21;
    run_stream(1, 1000, 100, 100, cyc);
    check("d4_cycles", cyc, 384);
    check("d4_pin0", cap[1][0], DEC ? 2497 : 12);
    check("d4_pin1", cap[1][1], DEC ? 624 : 3);
    check("d4_pin2", cap[1][2], DEC ? 208 : 1);
    check("d4_pin3", cap[1][3], DEC ? 416 : 2);
    idle_probe(1);

    // D=10: 0xFF,0x03,0,0,0 then random, output stalls.
    for (int k = 0; k < 352; k++) stim[k] = 8'($urandom);
    stim[0] = 8'hFF; stim[1] = 8'h03; stim[2] = 8'h00; stim[3] = 8'h00; stim[4] = 8'h00;
    run_stream(3, 1000, 100, 60, cyc);
    check("d10_pin0", cap[3][0], DEC ? 3326 : 1023);
    for (int k = 1; k < 4; k++) check($sformatf("d10_pin[%0d]", k), cap[3][k], 0);
    idle_probe(3);

    // D=11: random 352-byte stream with stalls on both sides.
    for (int k = 0; k < 352; k++) stim[k] = 8'($urandom);
    run_stream(4, 1000, 60, 50, cyc);
    idle_probe(4);

    // D=5: async reset after 40 bytes, then restart on the first cycle out of reset.
    for (int k = 0; k < 352; k++) stim[k] = 8'($urandom);
    run_stream(2, 40, 80, 70, cyc);
    #2;
    rst = 1'b1;
    #1;
    check("d5_async_rst_outputs",
          {in_ready[2], out_valid[2], out_last[2], busy[2], done[2], out_coeff[2]}, 0);
    check("d5_async_rst_busy", busy[2], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 352; k++) stim[k] = 8'($urandom);
    run_stream(2, 1000, 70, 60, cyc);
    y0 = int'(stim[0] & 8'h1F);
    check("d5_restart_coeff0", cap[2][0], DEC ? (3329 * y0 + 16) >> 5 : y0);
    idle_probe(2);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
